// File: rtl/wbvga_mem_arbiter_if.sv
// Pipelined Wishbone bus bundle shared by both masters and the memory port.
// The arbiter is the slave on the master-side buses and the master on memdev.
interface wbvga_mem_arbiter_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] sel;
  logic            stall;
  logic            ack;
  logic            err;
  logic [DW-1:0]   rdata;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  stall, ack, err, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output stall, ack, err, rdata
  );
endinterface

// File: rtl/wbvga_mem_arbiter.sv
// Two-master pipelined Wishbone arbiter in front of the frame-buffer memory:
// master A is the VGA fetcher (read-only), master B the drawing/host port.
module wbvga_mem_arbiter #(
  parameter int AW      = 24,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  wbvga_mem_arbiter_if.slave    a_bus,
  wbvga_mem_arbiter_if.slave    b_bus,
  wbvga_mem_arbiter_if.master   s_bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN_A,
    S_OWN_B,
    S_FLUSH
  } state_t;

  state_t        r_state;
  logic          r_last_b;
  logic [4:0]    r_outstanding;
  logic [TW-1:0] r_timer;

  logic w_owner_b;
  logic w_owner_cyc;
  logic w_owner_stb;
  logic w_other_cyc;
  logic w_own;
  logic w_waiting;
  logic w_timeout;
  logic w_active;
  logic w_full;
  logic w_stall;
  logic w_accept;
  logic w_ack;
  logic w_dec;
  logic w_unused;

  // r_last_b names the current owner while in OWN_x/FLUSH and the previous one in IDLE.
  assign w_owner_b   = r_last_b;
  assign w_owner_cyc = w_owner_b ? b_bus.cyc : a_bus.cyc;
  assign w_owner_stb = w_owner_b ? b_bus.stb : a_bus.stb;
  assign w_other_cyc = w_owner_b ? a_bus.cyc : b_bus.cyc;

  assign w_own     = ((r_state == S_OWN_A) || (r_state == S_OWN_B)) && w_owner_cyc;
  assign w_waiting = w_own && (r_outstanding != 5'd0) && !s_bus.ack;
  // Timeout fires on the TIMEOUT-th consecutive cycle with work pending and no ack.
  assign w_timeout = w_waiting && (r_timer == TW'(TIMEOUT - 1));
  assign w_active  = w_own && !w_timeout;
  assign w_full    = (r_outstanding == 5'd31);
  assign w_stall   = !w_active || s_bus.stall || w_full;
  assign w_accept  = w_active && w_owner_stb && !s_bus.stall && !w_full;
  assign w_ack     = w_active && s_bus.ack;
  assign w_dec     = w_ack && (r_outstanding != 5'd0);

  assign s_bus.cyc   = w_own;
  assign s_bus.stb   = w_active && w_owner_stb;
  assign s_bus.we    = w_active && w_owner_b && b_bus.we;
  assign s_bus.addr  = w_owner_b ? b_bus.addr  : a_bus.addr;
  assign s_bus.wdata = w_owner_b ? b_bus.wdata : '0;
  assign s_bus.sel   = w_owner_b ? b_bus.sel   : '1;

  assign a_bus.stall = w_owner_b  || w_stall;
  assign b_bus.stall = !w_owner_b || w_stall;
  assign a_bus.ack   = !w_owner_b && w_ack;
  assign b_bus.ack   = w_owner_b  && w_ack;
  assign a_bus.err   = !w_owner_b && w_timeout;
  assign b_bus.err   = w_owner_b  && w_timeout;
  assign a_bus.rdata = s_bus.rdata;
  assign b_bus.rdata = s_bus.rdata;

  // Master A never writes and memdev has no error line.
  assign w_unused = ^{a_bus.we, a_bus.wdata, a_bus.sel, s_bus.err};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_IDLE;
      r_last_b      <= 1'b1;
      r_outstanding <= 5'd0;
      r_timer       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_outstanding <= 5'd0;
          r_timer       <= '0;
          if (a_bus.cyc && (!b_bus.cyc || r_last_b)) begin
            r_state  <= S_OWN_A;
            r_last_b <= 1'b0;
          end else if (b_bus.cyc) begin
            r_state  <= S_OWN_B;
            r_last_b <= 1'b1;
          end
        end

        S_OWN_A, S_OWN_B: begin
          if (!w_owner_cyc) begin
            r_outstanding <= 5'd0;
            r_timer       <= '0;
            if (w_other_cyc) begin
              r_state  <= w_owner_b ? S_OWN_A : S_OWN_B;
              r_last_b <= !r_last_b;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_state       <= S_FLUSH;
            r_outstanding <= 5'd0;
            r_timer       <= '0;
          end else begin
            case ({w_accept, w_dec})
              2'b10:   r_outstanding <= r_outstanding + 5'd1;
              2'b01:   r_outstanding <= r_outstanding - 5'd1;
              default: r_outstanding <= r_outstanding;
            endcase
            r_timer <= w_waiting ? r_timer + TW'(1) : '0;
          end
        end

        S_FLUSH: begin
          // Late acks from the abandoned transfers are swallowed here.
          r_outstanding <= 5'd0;
          r_timer       <= '0;
          if (!w_owner_cyc) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbvga_mem_arbiter.sv
// Directed bench for wbvga_mem_arbiter: cycle table for arbitration and
// pipelined transfers, plus sequences for timeout, saturation and async reset.
module tb_wbvga_mem_arbiter;

  localparam int AW      = 24;
  localparam int DW      = 32;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  wbvga_mem_arbiter_if #(.AW(AW), .DW(DW)) a_if ();
  wbvga_mem_arbiter_if #(.AW(AW), .DW(DW)) b_if ();
  wbvga_mem_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

  wbvga_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .a_bus     (a_if),
    .b_bus     (b_if),
    .s_bus     (s_if)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // exp_ctl = {a_stall,a_ack,a_err, b_stall,b_ack,b_err, s_cyc,s_stb,s_we}
  typedef struct {
    logic [1:0]  a_cs;
    logic [23:0] a_addr;
    logic [2:0]  b_csw;
    logic [1:0]  s_sa;
    logic [8:0]  exp_ctl;
    logic [23:0] exp_addr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] a_cs, input logic [23:0] aa, input logic [2:0] b_csw,
                     input logic [1:0] s_sa, input logic [8:0] ctl, input logic [23:0] ea,
                     input logic [3:0] es, input logic [31:0] ed);
    vec_t v;
    v.a_cs = a_cs; v.a_addr = aa; v.b_csw = b_csw; v.s_sa = s_sa;
    v.exp_ctl = ctl; v.exp_addr = ea; v.exp_sel = es; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    a_if.cyc = 0; a_if.stb = 0; a_if.we = 0; a_if.addr = '0; a_if.wdata = '0; a_if.sel = '0;
    b_if.cyc = 0; b_if.stb = 0; b_if.we = 0; b_if.addr = 24'h100;
    b_if.wdata = 32'hDEADBEEF; b_if.sel = 4'b0011;
    s_if.stall = 0; s_if.ack = 0; s_if.err = 0; s_if.rdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " a_stall"}, a_if.stall, 1);
    chk({tag, " b_stall"}, b_if.stall, 1);
    chk({tag, " a_ack"},   a_if.ack,   0);
    chk({tag, " a_err"},   a_if.err,   0);
    chk({tag, " s_cyc"},   s_if.cyc,   0);
    chk({tag, " s_stb"},   s_if.stb,   0);
    chk({tag, " s_we"},    s_if.we,    0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wait;
    int acc;
    string nm;
    logic [8:0] got;

    rst_n = 1'b0;
    idle_inputs();
    a_if.cyc = 1; b_if.cyc = 1;
    #13;
    check_reset_outputs("reset");
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    // Arbitration after reset, handoff, alternation
    add(2'b10, 24'h0,  3'b100, 2'b00, 9'b100_100_000, 24'h0,   4'h0, 32'h0);
    add(2'b10, 24'h0,  3'b100, 2'b00, 9'b000_100_100, 24'h0,   4'h0, 32'h0);
    add(2'b00, 24'h0,  3'b100, 2'b00, 9'b100_100_000, 24'h0,   4'h0, 32'h0);
    add(2'b00, 24'h0,  3'b111, 2'b00, 9'b100_000_111, 24'h100, 4'h3, 32'hDEADBEEF);
    add(2'b00, 24'h0,  3'b100, 2'b01, 9'b100_010_100, 24'h0,   4'h0, 32'h0);
    add(2'b00, 24'h0,  3'b000, 2'b00, 9'b100_100_000, 24'h0,   4'h0, 32'h0);
    add(2'b10, 24'h0,  3'b100, 2'b00, 9'b100_100_000, 24'h0,   4'h0, 32'h0);
    add(2'b10, 24'h0,  3'b100, 2'b00, 9'b000_100_100, 24'h0,   4'h0, 32'h0);
    // A pipelined reads with B write pending, slave stall then 1-cycle acks
    add(2'b11, 24'h10, 3'b111, 2'b10, 9'b100_100_110, 24'h10,  4'hf, 32'h0);
    add(2'b11, 24'h10, 3'b111, 2'b00, 9'b000_100_110, 24'h10,  4'hf, 32'h0);
    add(2'b11, 24'h11, 3'b111, 2'b01, 9'b010_100_110, 24'h11,  4'hf, 32'h0);
    add(2'b11, 24'h12, 3'b111, 2'b01, 9'b010_100_110, 24'h12,  4'hf, 32'h0);
    add(2'b11, 24'h13, 3'b111, 2'b01, 9'b010_100_110, 24'h13,  4'hf, 32'h0);
    add(2'b10, 24'h13, 3'b111, 2'b01, 9'b010_100_100, 24'h0,   4'h0, 32'h0);
    // A releases, B write goes through unchanged
    add(2'b00, 24'h0,  3'b111, 2'b00, 9'b100_100_000, 24'h0,   4'h0, 32'h0);
    add(2'b00, 24'h0,  3'b111, 2'b00, 9'b100_000_111, 24'h100, 4'h3, 32'hDEADBEEF);
    add(2'b00, 24'h0,  3'b100, 2'b01, 9'b100_010_100, 24'h0,   4'h0, 32'h0);
    add(2'b00, 24'h0,  3'b000, 2'b00, 9'b100_100_000, 24'h0,   4'h0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      {a_if.cyc, a_if.stb} = vecs[i].a_cs;
      a_if.addr = vecs[i].a_addr;
      {b_if.cyc, b_if.stb, b_if.we} = vecs[i].b_csw;
      {s_if.stall, s_if.ack} = vecs[i].s_sa;
      s_if.rdata = 32'hC0DE0000 | 32'(i);
      #1;
      got = {a_if.stall, a_if.ack, a_if.err, b_if.stall, b_if.ack, b_if.err,
             s_if.cyc, s_if.stb, s_if.we};
      $display("vec %0d: ctl=%b exp=%b addr=%0h", i, got, vecs[i].exp_ctl, s_if.addr);
      nm = $sformatf("v%0d ctl", i);
      chk(nm, 32'(got), 32'(vecs[i].exp_ctl));
      chk($sformatf("v%0d a_rdata", i), a_if.rdata, 32'hC0DE0000 | 32'(i));
      chk($sformatf("v%0d b_rdata", i), b_if.rdata, 32'hC0DE0000 | 32'(i));
      if (vecs[i].exp_ctl[1]) begin
        chk($sformatf("v%0d s_addr", i), 32'(s_if.addr), 32'(vecs[i].exp_addr));
        chk($sformatf("v%0d s_sel", i),  32'(s_if.sel),  32'(vecs[i].exp_sel));
      end
      if (vecs[i].exp_ctl[0]) begin
        chk($sformatf("v%0d s_data", i), s_if.wdata, vecs[i].exp_data);
      end
    end

    // Timeout: one read outstanding, slave never acks
    @(negedge clk);
    idle_inputs();
    a_if.cyc = 1;
    @(negedge clk);
    a_if.stb = 1; a_if.addr = 24'h20;
    #1;
    chk("to accept a_stall", a_if.stall, 0);
    n_wait = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      a_if.stb = 0;
      #1;
      if (a_if.err) begin
        n_wait = k;
        chk("to b_err", b_if.err, 0);
        chk("to s_stb", s_if.stb, 0);
        break;
      end
    end
    $display("timeout: a_err after %0d cycles", n_wait);
    chk("to err cycle", n_wait, TIMEOUT);
    @(negedge clk);
    s_if.ack = 1;
    #1;
    chk("to s_cyc after err", s_if.cyc, 0);
    chk("to err pulse", a_if.err, 0);
    chk("to late ack dropped", a_if.ack, 0);
    @(negedge clk);
    s_if.ack = 0; a_if.cyc = 0;
    @(negedge clk);
    a_if.cyc = 1;
    #1;
    $display("flush exit: a_stall=%0b s_cyc=%0b", a_if.stall, s_if.cyc);
    chk("idle regrant stall", a_if.stall, 1);
    chk("idle regrant s_cyc", s_if.cyc, 0);
    @(negedge clk);
    #1;
    chk("regrant a_stall", a_if.stall, 0);
    chk("regrant s_cyc", s_if.cyc, 1);

    // Outstanding saturation: 40 strobes, no acks
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      a_if.stb = 1; a_if.addr = 24'(k);
      #1;
      if (a_if.stb && !a_if.stall) acc++;
    end
    $display("saturation: %0d strobes accepted", acc);
    chk("sat accepted", acc, 31);
    chk("sat a_stall", a_if.stall, 1);
    @(negedge clk);
    s_if.ack = 1;
    #1;
    chk("burst a_ack", a_if.ack, 1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-burst: s_cyc=%0b a_stall=%0b", s_if.cyc, a_if.stall);
    check_reset_outputs("async reset");
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post reset s_cyc", s_if.cyc, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
